change_dispenser: RTL

- Sequences the coin-return hoppers after a vending transaction.
- Takes a change amount in cents from the vending FSM and pays it out greedily: dollars first, then quarters.
- Talks to each hopper over a 4-phase req/ack handshake, tracks on-board coin inventory and flags jams by timeout.
- Sits between the vending FSM (money datapath) and the hopper drivers; its remaining-amount output can feed the existing BCD/seven-segment path.

---
 rtl/vend_pkg.sv | 21 ++
 rtl/change_dispenser_hs_timeout.sv | 31 +++
 rtl/change_dispenser.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared vending definitions: cents width, coin values and the
// change dispenser state encoding.
package vend_pkg;

  localparam int AMT_W = 12;

  localparam logic [AMT_W-1:0] COIN_DOLLAR  = 12'd100;
  localparam logic [AMT_W-1:0] COIN_QUARTER = 12'd25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_D_REQ,
    ST_D_REL,
    ST_Q_REQ,
    ST_Q_REL,
    ST_FIN,
    ST_FAULT
  } disp_state_t;

endpackage

// File: rtl/change_dispenser_hs_timeout.sv
// Handshake watchdog: down-counter reloaded on clr, decremented while en,
// terminal flag when LIMIT enabled cycles have elapsed since the last clear.
module hs_timeout #(
  parameter int LIMIT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
  localparam logic [W-1:0] LOAD = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  // Reload on clear, otherwise count down while enabled and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = en && (cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin-return sequencer: pays out change greedily (dollars, then quarters)
// over 4-phase req/ack hopper handshakes, tracks inventory, flags jams.
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | waiting for start; accepts inventory loads
// CHECK    | pick next coin (dollar, quarter) or finish
// D_REQ    | dollar_req high, waiting for dollar_ack
// D_REL    | waiting for dollar_ack to drop
// Q_REQ    | qtr_req high, waiting for qtr_ack
// Q_REL    | waiting for qtr_ack to drop
// FIN      | one-cycle done pulse
// FAULT    | handshake timed out; wait for clear_fault
module change_dispenser
  import vend_pkg::*;
#(
  parameter int TIMEOUT = 1000000,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             load_en,
  input  logic [3:0]       load_dollars,
  input  logic [3:0]       load_qtrs,
  input  logic             clear_fault,
  output logic             dollar_req,
  input  logic             dollar_ack,
  output logic             qtr_req,
  input  logic             qtr_ack,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic             jam,
  output logic [AMT_W-1:0] remain,
  output logic             dollar_empty,
  output logic             qtr_empty
);

  disp_state_t state, state_next;

  logic [CNT_W-1:0] dollar_cnt, qtr_cnt;
  logic [CNT_W:0]   dollar_sum, qtr_sum;
  logic [CNT_W-1:0] dollar_sat, qtr_sat;

  logic tmr_clr, tmr_en, tmr_tc;

  hs_timeout #(.LIMIT(TIMEOUT)) u_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  // The timer runs only while a handshake phase is open and restarts on
  // every state change, so each REQ and REL phase gets its own budget.
  assign tmr_en  = (state == ST_D_REQ) || (state == ST_D_REL) ||
                   (state == ST_Q_REQ) || (state == ST_Q_REL);
  assign tmr_clr = (state_next != state);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; an ack arriving on the timeout cycle still counts.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_CHECK;
      ST_CHECK: begin
        if ((remain >= COIN_DOLLAR) && (dollar_cnt != '0))
          state_next = ST_D_REQ;
        else if ((remain >= COIN_QUARTER) && (qtr_cnt != '0))
          state_next = ST_Q_REQ;
        else
          state_next = ST_FIN;
      end
      ST_D_REQ: begin
        if (dollar_ack)  state_next = ST_D_REL;
        else if (tmr_tc) state_next = ST_FAULT;
      end
      ST_D_REL: begin
        if (!dollar_ack) state_next = ST_CHECK;
        else if (tmr_tc) state_next = ST_FAULT;
      end
      ST_Q_REQ: begin
        if (qtr_ack)     state_next = ST_Q_REL;
        else if (tmr_tc) state_next = ST_FAULT;
      end
      ST_Q_REL: begin
        if (!qtr_ack)    state_next = ST_CHECK;
        else if (tmr_tc) state_next = ST_FAULT;
      end
      ST_FIN:   state_next = ST_IDLE;
      ST_FAULT: if (clear_fault) state_next = ST_FIN;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Saturating inventory load values.
  always_comb begin
    dollar_sum = (CNT_W+1)'(dollar_cnt) + (CNT_W+1)'(load_dollars);
    qtr_sum    = (CNT_W+1)'(qtr_cnt) + (CNT_W+1)'(load_qtrs);
    dollar_sat = dollar_sum[CNT_W] ? '1 : dollar_sum[CNT_W-1:0];
    qtr_sat    = qtr_sum[CNT_W] ? '1 : qtr_sum[CNT_W-1:0];
  end

  // Amount, inventory and short bookkeeping. short is updated on entry to
  // FIN so it is already valid alongside the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain     <= '0;
      short      <= 1'b0;
      dollar_cnt <= '0;
      qtr_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            remain <= change_amt;
            short  <= 1'b0;
          end else if (load_en) begin
            dollar_cnt <= dollar_sat;
            qtr_cnt    <= qtr_sat;
          end
        end
        ST_D_REQ: begin
          if (dollar_ack) begin
            dollar_cnt <= dollar_cnt - 1'b1;
            remain     <= remain - COIN_DOLLAR;
          end
        end
        ST_Q_REQ: begin
          if (qtr_ack) begin
            qtr_cnt <= qtr_cnt - 1'b1;
            remain  <= remain - COIN_QUARTER;
          end
        end
        default: ;
      endcase
      if ((state != ST_FIN) && (state_next == ST_FIN)) begin
        short <= (remain != '0);
      end
    end
  end

  assign dollar_req   = (state == ST_D_REQ);
  assign qtr_req      = (state == ST_Q_REQ);
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_FIN);
  assign jam          = (state == ST_FAULT);
  assign dollar_empty = (dollar_cnt == '0);
  assign qtr_empty    = (qtr_cnt == '0);

endmodule
